// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 32;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   // Arbiter FSM: waiting for a request, or owning memory for one port
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

endpackage : mem_arb_pkg

// File: rtl/arb_starve_cnt.sv
// Counts data grants that overtook a waiting fetch; flags when the fetch must win.
module arb_starve_cnt
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_limit_q;

   // Saturating increment; clear has priority over increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_W'(STARVE_LIMIT))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register plus a registered limit flag derived from the next count
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         at_limit_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         at_limit_q <= (cnt_d == CNT_W'(STARVE_LIMIT));
      end
   end

   assign at_limit = at_limit_q;

endmodule : arb_starve_cnt

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single request/ack memory port.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // instruction port
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic [DATA_W-1:0] i_rdata_o,
   output logic              i_valid_o,
   output logic              i_stall_o,
   // data port
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_valid_o,
   output logic              d_stall_o,
   // memory port
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   arb_state_e        state_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              i_valid_q;
   logic              d_valid_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic              i_elig;
   logic              d_elig;
   logic              gnt_inst;
   logic              gnt_data;
   logic              starve_inc;
   logic              starve_clr;
   logic              starve_at_limit;

   // Grant decision; a port completing this cycle sits out so a held request is not re-served
   always_comb begin
      i_elig     = i_req_i & ~i_valid_q;
      d_elig     = d_req_i & ~d_valid_q;
      gnt_data   = 1'b0;
      gnt_inst   = 1'b0;
      if (state_q == IDLE) begin
         gnt_data = d_elig & (~i_elig | ~starve_at_limit);
         gnt_inst = i_elig & ~gnt_data;
      end
      starve_inc = gnt_data & i_req_i;
      starve_clr = gnt_inst | (gnt_data & ~i_req_i);
   end

   arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .at_limit (starve_at_limit)
   );

   // Arbiter FSM with registered memory command, completion pulses and read data
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_valid_q   <= 1'b0;
         d_valid_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_data) begin
                  state_q     <= BUSY_D;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= d_we_i;
                  mem_addr_q  <= d_addr_i;
                  mem_wdata_q <= d_wdata_i;
               end else if (gnt_inst) begin
                  state_q    <= BUSY_I;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= i_addr_i;
               end
            end
            BUSY_I: begin
               if (mem_ack_i) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  i_valid_q <= 1'b1;
                  i_rdata_q <= mem_rdata_i;
               end
            end
            BUSY_D: begin
               if (mem_ack_i) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  d_valid_q <= 1'b1;
                  if (!mem_we_q) begin
                     d_rdata_q <= mem_rdata_i;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign i_valid_o   = i_valid_q;
   assign d_valid_o   = d_valid_q;
   assign i_rdata_o   = i_rdata_q;
   assign d_rdata_o   = d_rdata_q;

   // Stalls follow the request combinationally and release in the completion cycle
   assign i_stall_o   = i_req_i & ~i_valid_q;
   assign d_stall_o   = d_req_i & ~d_valid_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          i_req_i;
   logic [AW-1:0] i_addr_i;
   logic [DW-1:0] i_rdata_o;
   logic          i_valid_o;
   logic          i_stall_o;
   logic          d_req_i;
   logic          d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [DW-1:0] d_wdata_i;
   logic [DW-1:0] d_rdata_o;
   logic          d_valid_o;
   logic          d_stall_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_ack_i;
   logic [DW-1:0] mem_rdata_i;
   logic [2:0]    dut_cnt;

   int n_checks = 0;
   int n_err    = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIMIT)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .i_req_i     (i_req_i),
      .i_addr_i    (i_addr_i),
      .i_rdata_o   (i_rdata_o),
      .i_valid_o   (i_valid_o),
      .i_stall_o   (i_stall_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_rdata_o   (d_rdata_o),
      .d_valid_o   (d_valid_o),
      .d_stall_o   (d_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i)
   );

   assign dut_cnt = u_dut.u_starve.cnt_q;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rdata_for(input logic [AW-1:0] a);
      if (a == 32'h100) return 32'hDEAD_BEEF;
      return a ^ 32'h1357_9BDF;
   endfunction

   // Memory responder: acks after ack_delay cycles of mem_req_o, plus a manual override
   int   ack_delay = 0;
   int   busy_cnt  = 0;
   logic ack_auto  = 1'b0;
   logic ack_force = 1'b0;
   assign mem_ack_i = ack_auto | ack_force;

   initial mem_rdata_i = 32'hBADB_AD00;

   always begin
      @(posedge clk);
      #2;
      if (mem_req_o === 1'b1) begin
         if (busy_cnt == ack_delay) begin
            ack_auto    = 1'b1;
            mem_rdata_i = rdata_for(mem_addr_o);
         end else begin
            ack_auto    = 1'b0;
            mem_rdata_i = 32'hBADB_AD00;
         end
         busy_cnt++;
      end else begin
         ack_auto    = 1'b0;
         mem_rdata_i = 32'hBADB_AD00;
         busy_cnt    = 0;
      end
   end

   // Reference model: which port owns memory, latched command, pulses, returned words
   int            m_busy = 0;   // 0 none, 1 fetch, 2 data
   int            m_cnt  = 0;
   logic          m_we   = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic          m_ival = 1'b0;
   logic          m_dval = 1'b0;
   logic [DW-1:0] m_irdata = '0;
   logic [DW-1:0] m_drdata = '0;

   always @(posedge clk) begin
      logic ie, de;
      if (rst_i === 1'b1) begin
         m_busy = 0; m_cnt = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
         m_ival = 1'b0; m_dval = 1'b0; m_irdata = '0; m_drdata = '0;
      end else begin
         ie = i_req_i && !m_ival;
         de = d_req_i && !m_dval;
         m_ival = 1'b0;
         m_dval = 1'b0;
         if (m_busy == 0) begin
            if (de && (!ie || m_cnt < int'(LIMIT))) begin
               m_busy  = 2;
               m_addr  = d_addr_i;
               m_we    = d_we_i;
               m_wdata = d_wdata_i;
               m_cnt   = i_req_i ? ((m_cnt < int'(LIMIT)) ? m_cnt + 1 : int'(LIMIT)) : 0;
            end else if (ie) begin
               m_busy = 1;
               m_addr = i_addr_i;
               m_we   = 1'b0;
               m_cnt  = 0;
            end
         end else if (mem_ack_i) begin
            if (m_busy == 1) begin
               m_ival   = 1'b1;
               m_irdata = mem_rdata_i;
            end else begin
               m_dval = 1'b1;
               if (!m_we) m_drdata = mem_rdata_i;
            end
            m_busy = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mem_req",   mem_req_o,   m_busy != 0);
         chk("mem_we",    mem_we_o,    m_we);
         chk("mem_addr",  mem_addr_o,  m_addr);
         chk("mem_wdata", mem_wdata_o, m_wdata);
         chk("i_valid",   i_valid_o,   m_ival);
         chk("d_valid",   d_valid_o,   m_dval);
         chk("i_rdata",   i_rdata_o,   m_irdata);
         chk("d_rdata",   d_rdata_o,   m_drdata);
         chk("i_stall",   i_stall_o,   i_req_i & ~m_ival);
         chk("d_stall",   d_stall_o,   d_req_i & ~m_dval);
         chk("starve_cnt", dut_cnt,    m_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, chg, vcnt, ngr;
      logic prev_v, prev_req, igr, ivseen;

      rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_i_valid", i_valid_o, 0);
      chk("rst_d_valid", d_valid_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_cnt", dut_cnt, 0);
      rst_i = 1'b0;
      step();

      // Single fetch, same-cycle ack
      ack_delay = 0;
      i_addr_i = 32'h100; i_req_i = 1'b1;
      chk("t1_d_stall_c0", d_stall_o, 0);
      step();
      chk("t1_mem_req_c1", mem_req_o, 1);
      chk("t1_addr_c1", mem_addr_o, 32'h100);
      chk("t1_we_c1", mem_we_o, 0);
      chk("t1_ivalid_c1", i_valid_o, 0);
      step();
      chk("t1_ivalid_c2", i_valid_o, 1);
      chk("t1_rdata", i_rdata_o, 32'hDEAD_BEEF);
      chk("t1_mem_req_c2", mem_req_o, 0);
      chk("t1_d_stall_c2", d_stall_o, 0);
      step();
      chk("t1_ivalid_c3", i_valid_o, 0);
      chk("t1_no_regrant", mem_req_o, 0);
      i_req_i = 1'b0;
      step();

      // Simultaneous store and fetch: data first, then fetch
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'h55;
      i_req_i = 1'b1; i_addr_i = 32'h104;
      step();
      chk("t2_we", mem_we_o, 1);
      chk("t2_wdata", mem_wdata_o, 32'h55);
      chk("t2_addr_d", mem_addr_o, 32'h200);
      chk("t2_i_stall_c1", i_stall_o, 1);
      step();
      chk("t2_dvalid", d_valid_o, 1);
      chk("t2_i_stall_c2", i_stall_o, 1);
      step();
      chk("t2_addr_i", mem_addr_o, 32'h104);
      chk("t2_we_i", mem_we_o, 0);
      chk("t2_store_keeps_rdata", d_rdata_o, 0);
      d_req_i = 1'b0; d_we_i = 1'b0;
      step();
      chk("t2_ivalid", i_valid_o, 1);
      chk("t2_i_stall_c4", i_stall_o, 0);
      chk("t2_i_rdata", i_rdata_o, 32'h1357_9ADB);
      step();
      i_req_i = 1'b0;
      step();

      // Load with 5-cycle ack delay; request held through the completion edge
      ack_delay = 5;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
      hi = 0; chg = 0; vcnt = 0; prev_v = 1'b0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (mem_req_o) begin
            hi++;
            if (mem_addr_o != 32'h300) chg++;
         end
         if (d_valid_o) vcnt++;
         if (prev_v) d_req_i = 1'b0;
         prev_v = d_valid_o;
      end
      chk("t3_req_cycles", hi, 6);
      chk("t3_addr_changes", chg, 0);
      chk("t3_valid_pulses", vcnt, 1);
      chk("t3_d_rdata", d_rdata_o, 32'h1357_98DF);

      // Starvation: fetch waits (dropping only in data completion cycles) while loads keep coming
      ack_delay = 0;
      i_addr_i = 32'h400; d_addr_i = 32'h500; d_we_i = 1'b0;
      i_req_i = 1'b1; d_req_i = 1'b1;
      ngr = 0; igr = 1'b0; ivseen = 1'b0; prev_req = 1'b0;
      for (int c = 0; c < 60 && !ivseen; c++) begin
         step();
         if (mem_req_o && !prev_req) begin
            if (mem_addr_o == 32'h500 && !igr) begin
               ngr++;
               if (ngr == 4) chk("t4_cnt_at_limit", dut_cnt, 4);
            end else if (mem_addr_o == 32'h400 && !igr) begin
               igr = 1'b1;
               chk("t4_data_grants", ngr, 4);
               chk("t4_cnt_after_igrant", dut_cnt, 0);
               d_req_i = 1'b0;
            end
         end
         prev_req = mem_req_o;
         if (i_valid_o) ivseen = 1'b1;
         i_req_i = (d_valid_o && !igr) ? 1'b0 : 1'b1;
      end
      chk("t4_fetch_completed", ivseen, 1);
      chk("t4_fetch_rdata", i_rdata_o, 32'h1357_9FDF);
      step();
      i_req_i = 1'b0;
      step();

      // Reset in the middle of a load, followed by a stray ack in IDLE
      ack_delay = 100;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h600;
      step();
      chk("t5_busy", mem_req_o, 1);
      step();
      rst_i = 1'b1; d_req_i = 1'b0;
      step();
      rst_i = 1'b0;
      chk("t5_mem_req_after_rst", mem_req_o, 0);
      chk("t5_d_rdata_rst", d_rdata_o, 0);
      chk("t5_i_rdata_rst", i_rdata_o, 0);
      vcnt = 0; hi = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         ack_force = (c == 0);
         if (d_valid_o) vcnt++;
         if (mem_req_o) hi++;
      end
      ack_force = 1'b0;
      chk("t5_no_dvalid", vcnt, 0);
      chk("t5_no_mem_req", hi, 0);

      // Load after reset still works
      ack_delay = 1;
      d_req_i = 1'b1; d_addr_i = 32'h700;
      vcnt = 0; prev_v = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (d_valid_o) vcnt++;
         if (prev_v) d_req_i = 1'b0;
         prev_v = d_valid_o;
      end
      chk("t6_valid_pulses", vcnt, 1);
      chk("t6_d_rdata", d_rdata_o, 32'h1357_9CDF);

      step();
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; STARVE_LIMIT, 4, consecutive data grants tolerated while an instruction request waits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-004 Instruction port SHALL be: i_req_i  in  1  fetch request; i_addr_i  in  ADDR_W  fetch address; i_rdata_o  out  DATA_W  fetched word; i_valid_o  out  1  one-cycle completion pulse; i_stall_o  out  1  fetch stall.
REQ-005 Data port SHALL be: d_req_i  in  1  load/store request; d_we_i  in  1  1 = store; d_addr_i  in  ADDR_W  address; d_wdata_i  in  DATA_W  store data; d_rdata_o  out  DATA_W  load data; d_valid_o  out  1  one-cycle completion pulse; d_stall_o  out  1  MEM stall.
REQ-006 Memory port SHALL be: mem_req_o  out  1  access request; mem_we_o  out  1  write enable; mem_addr_o  out  ADDR_W  address; mem_wdata_o  out  DATA_W  write data; mem_ack_i  in  1  access done; mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i.

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, BUSY_I, BUSY_D.
REQ-008 Requesters SHALL hold req and address/data stable until their valid_o pulses; the arbiter SHALL NOT check this.
REQ-009 In IDLE, arbitration SHALL exclude any requester whose valid_o is high that cycle.
REQ-010 In IDLE, with only one eligible request, that requester SHALL be granted.
REQ-011 In IDLE, with both eligible, data SHALL win unless the starvation count equals STARVE_LIMIT, in which case instruction SHALL win.
REQ-012 A grant SHALL register the winner's address, we and wdata and move to BUSY_I or BUSY_D on the next edge.
REQ-013 Instruction grants SHALL drive mem_we_o = 0.
REQ-014 mem_req_o SHALL be 1 exactly while in a BUSY state; mem_addr_o, mem_we_o and mem_wdata_o SHALL hold the registered values throughout BUSY.
REQ-015 In BUSY_x with mem_ack_i = 1, the FSM SHALL go to IDLE, and x_valid_o SHALL pulse for exactly the next cycle.
REQ-016 When x_valid_o pulses for a read, x_rdata_o SHALL hold the mem_rdata_i value sampled at ack, held until the next completion on that port.
REQ-017 On a store completion, d_rdata_o SHALL keep its previous value.
REQ-018 Minimum latency SHALL be: request in IDLE at cycle 0, mem_req_o at cycle 1, ack at cycle 1, valid_o at cycle 2.
REQ-019 BUSY with mem_ack_i = 0 SHALL persist indefinitely, with no timeout.
REQ-020 mem_ack_i in IDLE SHALL be ignored.
REQ-021 Stalls SHALL be combinational: x_stall_o = x_req_i AND NOT x_valid_o.
REQ-022 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each data grant made while i_req_i = 1.
REQ-023 The starvation counter SHALL clear on any instruction grant and on any data grant made while i_req_i = 0.
REQ-024 The counter width SHALL be $clog2(STARVE_LIMIT+1).

Reset
REQ-025 While rst_i = 1 at an edge, state SHALL become IDLE, and the counter, mem_req_o, mem_we_o, i_valid_o and d_valid_o SHALL become 0.
REQ-026 On reset, mem_addr_o, mem_wdata_o, i_rdata_o and d_rdata_o SHALL become 0.
REQ-027 A reset during BUSY SHALL abandon the access: no valid_o pulse, and a late mem_ack_i SHALL be ignored per REQ-020.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY_I, BUSY_D) and the default ADDR_W/DATA_W constants.
REQ-029 The starvation counter SHALL be a sub-module, arb_starve_cnt (inputs: clk_i, rst_i, inc, clr; output: at_limit).
REQ-030 All other logic SHALL be in mem_arbiter.

Verification
REQ-031 Single fetch: i_req_i = 1, addr 0x100, memory acks the same cycle with 0xDEADBEEF -> mem_req_o at cycle 1, i_valid_o at cycle 2 only, i_rdata_o = 0xDEADBEEF, d_stall_o = 0 throughout.
REQ-032 Simultaneous requests: i_req_i and d_req_i both 1 at cycle 0, store 0x55 to 0x200 -> data served first with mem_we_o = 1 and mem_wdata_o = 0x55; fetch served next; i_stall_o high until its valid pulse.
REQ-033 Starvation: i_req_i held at 1 with d_req_i re-asserted after every completion, STARVE_LIMIT = 4 -> exactly 4 data grants, then an instruction grant, then the counter reads 0.
REQ-034 Ack delay: memory acks 5 cycles after mem_req_o rises -> mem_req_o high for 6 cycles, address stable, single valid pulse.
REQ-035 Reset mid-access: rst_i = 1 for one cycle during BUSY_D, memory acks 2 cycles later -> state IDLE, no d_valid_o pulse, mem_req_o = 0 after reset.
REQ-036 No re-grant on completion: d_req_i still 1 in the d_valid_o cycle, then dropped -> no second data access issued.
